// File: rtl/timer_alarm_sched.sv
// Multi-channel alarm scheduler sharing one free-running count across NCH channels.
// A round-robin scan checks one channel per cycle; the CPU reaches it through a registered enable/ready bus.
module timer_alarm_sched #(
  parameter int COUNTER_WIDTH = 32,
  parameter int NCH           = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     we,
  input  logic [2:0]               addr,
  input  logic [COUNTER_WIDTH-1:0] data_in,
  output logic                     ready,
  output logic [COUNTER_WIDTH-1:0] data_out,
  input  logic [COUNTER_WIDTH-1:0] time_in,
  output logic                     cnt_rst,
  output logic [NCH-1:0]           alarm,
  output logic                     irq
);

  localparam int W    = COUNTER_WIDTH;
  localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SELW-1:0] PTR_LAST = SELW'(NCH - 1);

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_STATUS = 3'd1;
  localparam logic [2:0] A_MASK   = 3'd2;
  localparam logic [2:0] A_SEL    = 3'd3;
  localparam logic [2:0] A_CMP    = 3'd4;
  localparam logic [2:0] A_PERIOD = 3'd5;
  localparam logic [2:0] A_CHCTRL = 3'd6;
  localparam logic [2:0] A_TIME   = 3'd7;

  // Wrap-safe deadline test: the signed distance from deadline to now is non-negative.
  function automatic logic deadline_reached(input logic [W-1:0] now, input logic [W-1:0] dl);
    logic [W-1:0] diff;
    diff = now - dl;
    return ~diff[W-1];
  endfunction

  logic            run_q, run_d;
  logic [NCH-1:0]  pending_q, pending_d;
  logic [NCH-1:0]  mask_q, mask_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [SELW-1:0] ptr_q, ptr_d;
  logic [W-1:0]    cmp_q    [NCH];
  logic [W-1:0]    cmp_d    [NCH];
  logic [W-1:0]    period_q [NCH];
  logic [W-1:0]    period_d [NCH];
  logic [NCH-1:0]  arm_q, arm_d;
  logic [NCH-1:0]  per_q, per_d;
  logic            ready_q, ready_d;
  logic [W-1:0]    data_out_q, data_out_d;
  logic            cnt_rst_q, cnt_rst_d;
  logic [NCH-1:0]  alarm_q, alarm_d;
  logic            irq_q, irq_d;

  logic            wr_s;
  logic            rd_s;
  logic            sel_ok_s;
  logic            fire_s;
  logic [W-1:0]    rdata_s;

  assign wr_s     = enable & we;
  assign rd_s     = enable & ~we;
  assign sel_ok_s = ({1'b0, sel_q} < (SELW+1)'(NCH));
  assign fire_s   = run_q & arm_q[ptr_q] & deadline_reached(time_in, cmp_q[ptr_q]);

  // Read mux over the current register state.
  always_comb begin
    rdata_s = '0;
    case (addr)
      A_CTRL:   rdata_s = W'(run_q);
      A_STATUS: rdata_s = W'(pending_q);
      A_MASK:   rdata_s = W'(mask_q);
      A_SEL:    rdata_s = W'(sel_q);
      A_CMP:    rdata_s = sel_ok_s ? cmp_q[sel_q] : '0;
      A_PERIOD: rdata_s = sel_ok_s ? period_q[sel_q] : '0;
      A_CHCTRL: rdata_s = sel_ok_s ? W'({per_q[sel_q], arm_q[sel_q]}) : '0;
      A_TIME:   rdata_s = time_in;
      default:  rdata_s = '0;
    endcase
  end

  // Next state: scan engine update first, then CPU writes so the CPU wins per field.
  always_comb begin
    run_d     = run_q;
    mask_d    = mask_q;
    sel_d     = sel_q;
    arm_d     = arm_q;
    per_d     = per_q;
    cmp_d     = cmp_q;
    period_d  = period_q;
    alarm_d   = '0;
    pending_d = pending_q;

    if (wr_s && (addr == A_STATUS)) begin
      pending_d = pending_q & ~data_in[NCH-1:0];
    end else begin
      pending_d = pending_q;
    end

    if (fire_s) begin
      pending_d[ptr_q] = 1'b1;
      alarm_d[ptr_q]   = 1'b1;
      if (per_q[ptr_q] && (period_q[ptr_q] != '0)) begin
        cmp_d[ptr_q] = cmp_q[ptr_q] + period_q[ptr_q];
      end else begin
        arm_d[ptr_q] = 1'b0;
      end
    end else begin
      alarm_d = '0;
    end

    if (wr_s) begin
      case (addr)
        A_CTRL: run_d  = data_in[0];
        A_MASK: mask_d = data_in[NCH-1:0];
        A_SEL:  sel_d  = (NCH > 1) ? data_in[SELW-1:0] : '0;
        A_CMP: begin
          if (sel_ok_s) cmp_d[sel_q] = data_in;
          else          cmp_d[0]     = cmp_d[0];
        end
        A_PERIOD: begin
          if (sel_ok_s) period_d[sel_q] = data_in;
          else          period_d[0]     = period_d[0];
        end
        A_CHCTRL: begin
          if (sel_ok_s) begin
            arm_d[sel_q] = data_in[0];
            per_d[sel_q] = data_in[1];
          end else begin
            arm_d = arm_d;
          end
        end
        default: run_d = run_d;
      endcase
    end else begin
      run_d = run_d;
    end

    if (run_q) begin
      if (ptr_q == PTR_LAST) ptr_d = '0;
      else                   ptr_d = ptr_q + 1'b1;
    end else begin
      ptr_d = ptr_q;
    end

    ready_d    = enable;
    data_out_d = rd_s ? rdata_s : data_out_q;
    cnt_rst_d  = wr_s && (addr == A_CTRL) && data_in[1];
    irq_d      = |(pending_d & mask_d);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      pending_q  <= '0;
      mask_q     <= '0;
      sel_q      <= '0;
      ptr_q      <= '0;
      arm_q      <= '0;
      per_q      <= '0;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i]    <= '0;
        period_q[i] <= '0;
      end
      ready_q    <= 1'b0;
      data_out_q <= '0;
      cnt_rst_q  <= 1'b0;
      alarm_q    <= '0;
      irq_q      <= 1'b0;
    end else begin
      run_q      <= run_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      sel_q      <= sel_d;
      ptr_q      <= ptr_d;
      arm_q      <= arm_d;
      per_q      <= per_d;
      for (int i = 0; i < NCH; i++) begin
        cmp_q[i]    <= cmp_d[i];
        period_q[i] <= period_d[i];
      end
      ready_q    <= ready_d;
      data_out_q <= data_out_d;
      cnt_rst_q  <= cnt_rst_d;
      alarm_q    <= alarm_d;
      irq_q      <= irq_d;
    end
  end

  assign ready    = ready_q;
  assign data_out = data_out_q;
  assign cnt_rst  = cnt_rst_q;
  assign alarm    = alarm_q;
  assign irq      = irq_q;

endmodule

// File: doc/timer_alarm_sched.md
# timer_alarm_sched

Multi-channel alarm scheduler that sits beside the free-running `time_counter` and shares its single count among NCH software alarm channels. A round-robin scan engine compares one channel per cycle against the live count and sets a pending flag when the channel's deadline is reached. It can reload periodic deadlines, raise a masked interrupt, and issue the counter's soft-reset pulse on CPU request. The CPU accesses it through the same enable/ready register interface as the other peripherals.

## Interface
- COUNTER_WIDTH, 32: width of the time value, compare, period and data buses.
- NCH, 4: number of alarm channels, 1..8.
- clk  in  1  system clock, all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  CPU access strobe, one cycle per access.
- we  in  1  write qualifier; high during enable means write, low means read.
- addr  in  3  register select.
- data_in  in  COUNTER_WIDTH  write data.
- ready  out  1  access acknowledge.
- data_out  out  COUNTER_WIDTH  read data, valid while ready is high.
- time_in  in  COUNTER_WIDTH  live count from time_counter.
- cnt_rst  out  1  one-cycle soft-reset pulse to time_counter.
- alarm  out  NCH  one-cycle fire pulse per channel.
- irq  out  1  level interrupt.

## Operation
- Register map by addr:
  - 0 CTRL: bit0 RUN, read/write; bit1 CNT_RST, write-only, reads 0.
  - 1 STATUS: pending[NCH-1:0]; read; write-1-to-clear.
  - 2 MASK: irq mask[NCH-1:0].
  - 3 SEL: channel index, only the low ceil(log2 NCH) bits are stored; index ≥ NCH aliases modulo 2^bits, and writes to a non-existent channel are ignored.
  - 4 CMP: deadline of the selected channel.
  - 5 PERIOD: reload period of the selected channel.
  - 6 CHCTRL: bit0 ARM, bit1 PERIODIC of the selected channel.
  - 7 TIME: read-only, returns time_in.
- Unused bits read 0. Writes to read-only fields are ignored.
- Scan engine:
  - A pointer p cycles 0..NCH-1, advancing one step per cycle while RUN=1.
  - While RUN=0 the pointer holds and no channel fires.
- Fire condition for channel p: ARM=1 and the signed interpretation of (time_in − CMP[p]) mod 2^COUNTER_WIDTH is ≥ 0. This makes the check wrap-safe for deadlines within 2^(W−1) ticks.
- On fire:
  - Set pending[p] and pulse alarm[p] for one cycle.
  - If PERIODIC=1 and PERIOD≠0: CMP[p] ← CMP[p]+PERIOD (mod 2^W), ARM stays 1.
  - Otherwise ARM[p] ← 0.
  - A late periodic channel catches up one period per visit; missed periods are not counted.
- irq = |(pending & MASK), driven from registers with no combinational path from bus inputs.
- CNT_RST: writing CTRL with bit1=1 drives cnt_rst high for exactly the next cycle. Channel CMP values are not modified by a counter reset.
- Simultaneous events:
  - A STATUS write-1-to-clear on the same cycle as a fire of that channel leaves pending set.
  - A CPU write to CMP or CHCTRL of channel p on the cycle p fires: the CPU value wins for the written field; pending is still set.
- Reset (rst_n low, asynchronous):
  - All registers, pending, MASK, SEL and the pointer go to 0.
  - ready, data_out, cnt_rst, alarm and irq go to 0.
  - Reset asserted mid-operation aborts any access in progress with no ready.

## Timing
- Access latency:
  - ready is asserted the cycle after enable, for one cycle per enable cycle.
  - data_out is registered and updated on that same edge; it holds its value otherwise.
  - Writes take effect at the edge that samples enable.
- Fire latency: from time_in first satisfying the condition to the alarm pulse is at most NCH cycles (scan visit plus one register stage).
  - pending and irq rise on the same edge as alarm.
- Back-to-back accesses on consecutive cycles are legal; each receives its own ready.
- cnt_rst rises one cycle after the CTRL write edge; the count is 0 one cycle after that.
- A read of STATUS on the cycle a fire occurs returns the pre-fire value.

## Test plan
- Reset: hold rst_n=0 with random inputs, then release -> ready, data_out, cnt_rst, alarm and irq all 0; all registers read 0.
- One-shot, NCH=4:
  - Setup: RUN=1, SEL=2, CMP=100, CHCTRL=1, MASK=4, time_in counting from 0.
  - Expect: a single alarm[2] pulse with time_in in 100..103, irq=1, STATUS=4, ARM reads 0.
  - Then write STATUS=4 -> irq=0.
- Periodic: CMP=50, PERIOD=20, CHCTRL=3 -> alarm pulses near times 50, 70, 90, 110; CMP reads 130 after the fourth pulse.
- Wrap-around: CMP=0x0000_0005 with time_in starting at 0xFFFF_FFF0 -> no fire before the wrap; fire once time_in ≥ 5 after the wrap.
- Collision: STATUS clear on the same cycle channel 1 fires -> pending[1] stays 1. A CHCTRL write of 0 on the fire cycle -> ARM=0 regardless of PERIODIC.
- CNT_RST: write CTRL=3 -> cnt_rst high exactly one cycle, then TIME reads small values; RUN=0 blocks all alarms even past the deadline.
